// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: serialises one written byte LSB-first on TxD,
// advancing one bit every OVERSAMPLE sample_ENABLE ticks.
module uart_tx_sequencer #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_ENABLE,
   input  logic                 Tx_EN,
   input  logic                 Tx_WR,
   input  logic [DATA_BITS-1:0] Tx_DATA,
   output logic                 TxD,
   output logic                 Tx_BUSY,
   output logic                 Tx_DONE
);

   localparam int unsigned      CNT_W     = 4;
   localparam int unsigned      IDX_W     = 3;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state,    w_state_nxt;
   logic [CNT_W-1:0]     r_tick_cnt, w_tick_cnt_nxt;
   logic [IDX_W-1:0]     r_bit_idx,  w_bit_idx_nxt;
   logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
   logic                 r_parity,   w_parity_nxt;
   logic                 r_txd,      w_txd_nxt;
   logic                 r_busy,     w_busy_nxt;
   logic                 r_done,     w_done_nxt;
   logic                 w_accept;
   logic                 w_bit_end;

   // Busy still high during the DONE cycle, so a write coincident with DONE is dropped
   assign w_accept  = Tx_WR & Tx_EN & (r_state == S_IDLE) & ~r_busy;
   assign w_bit_end = sample_ENABLE & (r_state != S_IDLE) & (r_tick_cnt == CNT_LAST);

   assign TxD     = r_txd;
   assign Tx_BUSY = r_busy;
   assign Tx_DONE = r_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_txd      <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_parity   <= w_parity_nxt;
         r_txd      <= w_txd_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // Next-state, bit sequencing and registered line/status values
   always_comb begin
      w_state_nxt    = r_state;
      w_tick_cnt_nxt = r_tick_cnt;
      w_bit_idx_nxt  = r_bit_idx;
      w_shift_nxt    = r_shift;
      w_parity_nxt   = r_parity;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_txd_nxt      = 1'b1;

      if ((r_state != S_IDLE) && sample_ENABLE) begin
         w_tick_cnt_nxt = w_bit_end ? '0 : r_tick_cnt + CNT_W'(1);
      end

      unique case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            if (w_accept) begin
               w_state_nxt    = S_START;
               w_tick_cnt_nxt = '0;
               w_bit_idx_nxt  = '0;
               w_shift_nxt    = Tx_DATA;
               w_parity_nxt   = (^Tx_DATA) ^ 1'(PARITY_ODD);
               w_busy_nxt     = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt   = S_DATA;
               w_bit_idx_nxt = '0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_shift_nxt   = r_shift >> 1;
               w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
               if (r_bit_idx == DATA_LAST) begin
                  w_bit_idx_nxt = '0;
                  w_state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt   = S_STOP;
               w_bit_idx_nxt = '0;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (r_bit_idx == STOP_LAST) begin
                  w_state_nxt   = S_IDLE;
                  w_bit_idx_nxt = '0;
                  w_done_nxt    = 1'b1;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      case (w_state_nxt)
         S_START:  w_txd_nxt = 1'b0;
         S_DATA:   w_txd_nxt = w_shift_nxt[0];
         S_PARITY: w_txd_nxt = w_parity_nxt;
         default:  w_txd_nxt = 1'b1;
      endcase
   end

endmodule
